// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks the columns, snapshots a full frame of row
// samples, and debounces one key at a time into a code/valid/held interface.
module keypad_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] kb_row_i,
  output logic [3:0] kb_col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o,
  output logic       key_multi_o
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_N + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    col_idx;
  logic [15:0]   snapshot;
  logic          frame_end;
  logic          dwell_end;

  state_t        state, state_next;
  logic [CW-1:0] deb_cnt, deb_next, deb_inc;
  logic [3:0]    cand, cand_next;
  logic [3:0]    code_next;
  logic          valid_next;
  logic          multi_next;
  logic [4:0]    nkeys;
  logic [3:0]    single_code;
  logic          single;
  logic          cand_down;

  assign dwell_end = (dwell_cnt == DW'(SCAN_DIV - 1));
  assign kb_col_o  = ~(4'b0001 << col_idx);

  // Rows are sampled at the end of each dwell, long after the column switched,
  // so the two-flop synchronizer lag still leaves settle time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_meta  <= 4'hF;
      row_sync  <= 4'hF;
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
      snapshot  <= 16'h0000;
      frame_end <= 1'b0;
    end else begin
      row_meta  <= kb_row_i;
      row_sync  <= row_meta;
      frame_end <= 1'b0;
      if (dwell_end) begin
        dwell_cnt <= '0;
        col_idx   <= col_idx + 2'd1;
        for (int r = 0; r < 4; r++) begin
          snapshot[4*r + int'(col_idx)] <= ~row_sync[r];
        end
        frame_end <= (col_idx == 2'd3);
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nkeys       = 5'd0;
    single_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) begin
        nkeys       = nkeys + 1'b1;
        single_code = 4'(i);
      end
    end
  end

  assign single    = (nkeys == 5'd1);
  assign cand_down = snapshot[cand];
  assign deb_inc   = deb_cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      cand        <= 4'd0;
      key_code_o  <= 4'd0;
      key_valid_o <= 1'b0;
      key_multi_o <= 1'b0;
    end else begin
      state       <= state_next;
      deb_cnt     <= deb_next;
      cand        <= cand_next;
      key_code_o  <= code_next;
      key_valid_o <= valid_next;
      key_multi_o <= multi_next;
    end
  end

  // The debounce FSM only moves on the cycle after a frame completes.
  always_comb begin
    state_next = state;
    deb_next   = deb_cnt;
    cand_next  = cand;
    code_next  = key_code_o;
    valid_next = 1'b0;
    multi_next = key_multi_o;
    if (frame_end) begin
      multi_next = (nkeys >= 5'd2);
      case (state)
        IDLE: begin
          if (single) begin
            state_next = PRESS_CHK;
            cand_next  = single_code;
            deb_next   = CW'(1);
          end
        end
        PRESS_CHK: begin
          if (single && (single_code == cand)) begin
            deb_next = deb_inc;
            if (deb_inc == CW'(DEBOUNCE_N)) begin
              state_next = HELD;
              code_next  = cand;
              valid_next = 1'b1;
            end
          end else begin
            state_next = IDLE;
            deb_next   = '0;
          end
        end
        HELD: begin
          if (!cand_down) begin
            state_next = RELEASE_CHK;
            deb_next   = CW'(1);
          end
        end
        RELEASE_CHK: begin
          if (!cand_down) begin
            deb_next = deb_inc;
            if (deb_inc == CW'(DEBOUNCE_N)) begin
              state_next = IDLE;
              deb_next   = '0;
            end
          end else begin
            state_next = HELD;
            deb_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          deb_next   = '0;
        end
      endcase
    end
  end

  assign key_held_o = (state == HELD) || (state == RELEASE_CHK);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 switch matrix;
// SCAN_DIV=8, DEBOUNCE_N=3 so one frame is 32 clocks.
module tb_keypad_scan;

  localparam int FRAME   = 32;
  localparam int MAX_LAT = 4 * FRAME + 3;

  logic        clk;
  logic        rst_i;
  logic [3:0]  kb_row;
  logic [3:0]  kb_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        key_multi;
  logic [15:0] keys;

  int tests_run    = 0;
  int tests_failed = 0;
  int pulse_count  = 0;
  int base;
  int waited;

  keypad_scan #(.SCAN_DIV(8), .DEBOUNCE_N(3)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .kb_row_i   (kb_row),
    .kb_col_o   (kb_col),
    .key_code_o (key_code),
    .key_valid_o(key_valid),
    .key_held_o (key_held),
    .key_multi_o(key_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed switch at (row r, col c) pulls row r low while column c is driven low.
  always_comb begin
    kb_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (|(keys[4*r +: 4] & ~kb_col)) kb_row[r] = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (key_valid) pulse_count++;
  end

  task automatic applyStimulus(input logic [15:0] k, input int cycles);
    keys = k;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitPulse(input int max_cycles, output int n);
    int start;
    start = pulse_count;
    n = 0;
    while (pulse_count == start && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst_i = 1'b1;
    keys  = 16'h0000;
    repeat (3) @(negedge clk);

    // 1: reset state and column walk
    checkOutput("rst_col",   kb_col,    4'b1110);
    checkOutput("rst_code",  key_code,  4'h0);
    checkOutput("rst_valid", key_valid, 1'b0);
    checkOutput("rst_held",  key_held,  1'b0);
    checkOutput("rst_multi", key_multi, 1'b0);
    rst_i = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("col0_dwell", kb_col, 4'b1110);
    @(negedge clk);
    checkOutput("col1", kb_col, 4'b1101);
    repeat (8) @(negedge clk);
    checkOutput("col2", kb_col, 4'b1011);
    repeat (8) @(negedge clk);
    checkOutput("col3", kb_col, 4'b0111);
    repeat (8) @(negedge clk);
    checkOutput("col_wrap", kb_col, 4'b1110);
    applyStimulus(16'h0000, 2 * FRAME);
    checkOutput("idle_pulses", pulse_count, 0);
    checkOutput("idle_held",   key_held,    1'b0);

    // 2: stable press of row2/col1
    base = pulse_count;
    keys = 16'h0001 << 9;
    waitPulse(MAX_LAT, waited);
    checkOutput("t2_pulse",      pulse_count - base, 1);
    checkOutput("t2_valid_high", key_valid, 1'b1);
    checkOutput("t2_code",       key_code,  4'h9);
    @(negedge clk);
    checkOutput("t2_valid_once", key_valid, 1'b0);
    checkOutput("t2_held",       key_held,  1'b1);
    applyStimulus(16'h0001 << 9, 3 * FRAME);
    checkOutput("t2_no_repeat",  pulse_count - base, 1);
    checkOutput("t2_still_held", key_held, 1'b1);
    applyStimulus(16'h0000, 5 * FRAME);
    checkOutput("t2_released",   key_held, 1'b0);
    checkOutput("t2_code_kept",  key_code, 4'h9);

    // 3: bounce shorter than the debounce window
    base = pulse_count;
    applyStimulus(16'h0001 << 9, 2 * FRAME);
    applyStimulus(16'h0000, 4 * FRAME);
    checkOutput("t3_no_pulse", pulse_count - base, 0);
    checkOutput("t3_not_held", key_held, 1'b0);

    // 4: row0/col3 with a one-frame dropout while held, then a re-press
    base = pulse_count;
    keys = 16'h0001 << 3;
    waitPulse(MAX_LAT, waited);
    checkOutput("t4_pulse", pulse_count - base, 1);
    checkOutput("t4_code",  key_code, 4'h3);
    applyStimulus(16'h0001 << 3, 2 * FRAME);
    applyStimulus(16'h0000, FRAME);
    applyStimulus(16'h0001 << 3, 4 * FRAME);
    checkOutput("t4_dropout_one_pulse", pulse_count - base, 1);
    checkOutput("t4_dropout_held",      key_held, 1'b1);
    applyStimulus(16'h0000, 5 * FRAME);
    checkOutput("t4_released", key_held, 1'b0);
    keys = 16'h0001 << 3;
    waitPulse(MAX_LAT, waited);
    checkOutput("t4_second_pulse", pulse_count - base, 2);
    checkOutput("t4_second_code",  key_code, 4'h3);
    applyStimulus(16'h0000, 5 * FRAME);

    // 5: two keys down (row1/col0 and row3/col2), then one released
    base = pulse_count;
    applyStimulus((16'h0001 << 4) | (16'h0001 << 14), 80);
    checkOutput("t5_multi", key_multi, 1'b1);
    applyStimulus((16'h0001 << 4) | (16'h0001 << 14), 5 * FRAME);
    checkOutput("t5_multi_no_pulse", pulse_count - base, 0);
    checkOutput("t5_multi_not_held", key_held, 1'b0);
    keys = 16'h0001 << 4;
    waitPulse(MAX_LAT, waited);
    checkOutput("t5_single_pulse", pulse_count - base, 1);
    checkOutput("t5_code",         key_code,  4'h4);
    checkOutput("t5_multi_clear",  key_multi, 1'b0);
    @(negedge clk);
    checkOutput("t5_held", key_held, 1'b1);

    // 6: one-cycle reset while held with the key still down
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    checkOutput("t6_code",  key_code,  4'h0);
    checkOutput("t6_valid", key_valid, 1'b0);
    checkOutput("t6_held",  key_held,  1'b0);
    checkOutput("t6_multi", key_multi, 1'b0);
    checkOutput("t6_col",   kb_col,    4'b1110);
    base = pulse_count;
    waitPulse(MAX_LAT, waited);
    checkOutput("t6_repulse",     pulse_count - base, 1);
    checkOutput("t6_not_early",   waited > 2 * FRAME, 1'b1);
    checkOutput("t6_code_again",  key_code, 4'h4);
    applyStimulus(16'h0000, 5 * FRAME);
    checkOutput("t6_released", key_held, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
